// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt and timer controller: Count/Compare with prescaler, Cause.IP pending
// field, synchronised level/edge external lines and the interrupt request/priority encode.
module cp0_int_ctrl #(
   parameter int unsigned NUM_HW_INT      = 6,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter logic [5:0]  EDGE_MASK       = 6'b000000,
   parameter int unsigned COUNT_DIV       = 2,
   parameter bit          COMPARE_ZERO_EN = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall_i,
   input  logic                  wr_en_i,
   input  logic [4:0]            wr_addr_i,
   input  logic [31:0]           wr_data_i,
   input  logic [31:0]           status_i,
   input  logic [NUM_HW_INT-1:0] int_i,
   input  logic [NUM_HW_INT-1:0] int_ack_i,
   output logic [31:0]           count_o,
   output logic [31:0]           compare_o,
   output logic [7:0]            ip_o,
   output logic                  timer_int_o,
   output logic                  int_req_o,
   output logic [2:0]            int_id_o
);

   localparam int unsigned     PRE_W        = 3;
   localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(COUNT_DIV - 1);
   localparam logic [4:0]      ADDR_COUNT   = 5'd9;
   localparam logic [4:0]      ADDR_COMPARE = 5'd11;
   localparam logic [4:0]      ADDR_CAUSE   = 5'd13;
   localparam logic [NUM_HW_INT-1:0] EDGE_M = EDGE_MASK[NUM_HW_INT-1:0];

   logic [PRE_W-1:0]      presc_q, presc_d;
   logic [31:0]           count_q, count_d;
   logic [31:0]           compare_q, compare_d;
   logic                  timer_q, timer_d;
   logic [1:0]            sw_q, sw_d;
   logic [NUM_HW_INT-1:0] sync_q [SYNC_STAGES];
   logic [NUM_HW_INT-1:0] sync_d [SYNC_STAGES];
   logic [NUM_HW_INT-1:0] s_dly_q, s_dly_d;
   logic [NUM_HW_INT-1:0] rise_q, rise_d;
   logic [NUM_HW_INT-1:0] pend_q, pend_d;

   logic                  wr_ok, wr_count, wr_compare, wr_cause;
   logic                  tick, timer_hit;
   logic [NUM_HW_INT-1:0] s;
   logic [5:0]            pend_ext;
   logic [7:0]            masked;
   logic [2:0]            id;
   logic                  unused_status;

   assign unused_status = ^{status_i[31:16], status_i[7:3]};

   assign wr_ok      = wr_en_i & ~stall_i;
   assign wr_count   = wr_ok && (wr_addr_i == ADDR_COUNT);
   assign wr_compare = wr_ok && (wr_addr_i == ADDR_COMPARE);
   assign wr_cause   = wr_ok && (wr_addr_i == ADDR_CAUSE);
   assign tick       = (presc_q == PRE_LAST);
   assign timer_hit  = (count_q == compare_q) && ((compare_q != 32'd0) || COMPARE_ZERO_EN);

   // Prescaler and Count; a Count write overrides a coincident tick
   always_comb begin
      presc_d = presc_q + PRE_W'(1);
      count_d = count_q;
      if (tick) begin
         presc_d = '0;
         count_d = count_q + 32'd1;
      end
      if (wr_count) begin
         presc_d = '0;
         count_d = wr_data_i;
      end
   end

   // Compare write clears the sticky timer flag, winning over a same-cycle match
   always_comb begin
      timer_d   = timer_q | timer_hit;
      compare_d = compare_q;
      sw_d      = sw_q;
      if (wr_compare) begin
         timer_d   = 1'b0;
         compare_d = wr_data_i;
      end
      if (wr_cause) begin
         sw_d = wr_data_i[9:8];
      end
   end

   always_comb begin
      sync_d[0] = int_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Edge lines register the rise before setting pend; set beats a same-cycle ack
   always_comb begin
      s_dly_d = s;
      rise_d  = EDGE_M & s & ~s_dly_q;
      pend_d  = (EDGE_M & (rise_q | (pend_q & ~int_ack_i))) | (~EDGE_M & s);
   end

   always_comb begin
      pend_ext                 = '0;
      pend_ext[NUM_HW_INT-1:0] = pend_q;
   end

   assign ip_o   = {pend_ext[5] | timer_q, pend_ext[4:0], sw_q};
   assign masked = ip_o & status_i[15:8];

   always_comb begin
      id = '0;
      for (int i = 0; i < 8; i++) begin
         if (masked[i]) id = 3'(i);
      end
   end

   assign int_req_o   = status_i[0] & ~status_i[1] & ~status_i[2] & (|masked);
   assign int_id_o    = id;
   assign count_o     = count_q;
   assign compare_o   = compare_q;
   assign timer_int_o = timer_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q   <= '0;
         count_q   <= '0;
         compare_q <= '0;
         timer_q   <= 1'b0;
         sw_q      <= '0;
         s_dly_q   <= '0;
         rise_q    <= '0;
         pend_q    <= '0;
         for (int i = 0; i < int'(SYNC_STAGES); i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         presc_q   <= presc_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         timer_q   <= timer_d;
         sw_q      <= sw_d;
         s_dly_q   <= s_dly_d;
         rise_q    <= rise_d;
         pend_q    <= pend_d;
         for (int i = 0; i < int'(SYNC_STAGES); i++) begin
            sync_q[i] <= sync_d[i];
         end
      end
   end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Self-checking bench for cp0_int_ctrl: directed scenarios plus a randomized phase
// checked against a cycle-history reference model.
module tb_cp0_int_ctrl;

   localparam int unsigned DIV  = 2;
   localparam logic [5:0]  EDGE = 6'b000001;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_i, wr_en_i;
   logic [4:0]  wr_addr_i;
   logic [31:0] wr_data_i, status_i;
   logic [5:0]  int_i, int_ack_i;
   logic [31:0] count_o, compare_o;
   logic [7:0]  ip_o;
   logic        timer_int_o, int_req_o;
   logic [2:0]  int_id_o;
   logic [31:0] count1;
   logic [31:0] unused_compare1;
   logic [7:0]  unused_ip1;
   logic        unused_timer1, unused_req1;
   logic [2:0]  unused_id1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cp0_int_ctrl #(.NUM_HW_INT(6), .SYNC_STAGES(2), .EDGE_MASK(EDGE),
                  .COUNT_DIV(DIV), .COMPARE_ZERO_EN(1'b0)) u_dut (
      .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .wr_en_i(wr_en_i),
      .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .status_i(status_i),
      .int_i(int_i), .int_ack_i(int_ack_i), .count_o(count_o),
      .compare_o(compare_o), .ip_o(ip_o), .timer_int_o(timer_int_o),
      .int_req_o(int_req_o), .int_id_o(int_id_o));

   // Second instance only for the divide-by-one Count behaviour
   cp0_int_ctrl #(.NUM_HW_INT(6), .SYNC_STAGES(2), .EDGE_MASK(EDGE),
                  .COUNT_DIV(1), .COMPARE_ZERO_EN(1'b0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .wr_en_i(wr_en_i),
      .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .status_i(status_i),
      .int_i(int_i), .int_ack_i(int_ack_i), .count_o(count1),
      .compare_o(unused_compare1), .ip_o(unused_ip1), .timer_int_o(unused_timer1),
      .int_req_o(unused_req1), .int_id_o(unused_id1));

   // Reference model: Count as base + elapsed/div, lines from a sample history
   logic [31:0] m_base, m_compare;
   int          m_elapsed;
   logic        m_timer;
   logic [1:0]  m_sw;
   logic [5:0]  m_pend;
   logic [5:0]  m_hist[$];

   function automatic logic [31:0] m_count(input int div);
      return m_base + 32'(m_elapsed / div);
   endfunction

   function automatic logic [7:0] m_ip();
      return {m_pend[5] | m_timer, m_pend[4:0], m_sw};
   endfunction

   function automatic logic [2:0] m_id(input logic [7:0] m);
      for (int i = 7; i >= 0; i--) if (m[i]) return 3'(i);
      return 3'd0;
   endfunction

   function automatic void model_reset();
      m_base = '0; m_elapsed = 0; m_compare = '0; m_timer = 1'b0;
      m_sw = '0; m_pend = '0;
      m_hist.delete();
      repeat (5) m_hist.push_back(6'd0);
   endfunction

   function automatic void model_step();
      logic        we;
      logic [31:0] c;
      logic [5:0]  rose;
      we = wr_en_i & ~stall_i;
      c  = m_count(DIV);
      if (we && wr_addr_i == 5'd11) begin
         m_timer = 1'b0; m_compare = wr_data_i;
      end else if (c == m_compare && m_compare != 32'd0) begin
         m_timer = 1'b1;
      end
      if (we && wr_addr_i == 5'd9) begin
         m_base = wr_data_i; m_elapsed = 0;
      end else begin
         m_elapsed++;
      end
      if (we && wr_addr_i == 5'd13) m_sw = wr_data_i[9:8];
      m_hist.push_front(int_i);
      void'(m_hist.pop_back());
      // level: sample from two edges back; edge: a 0->1 seen three/four edges back
      rose   = m_hist[3] & ~m_hist[4];
      m_pend = (~EDGE & m_hist[2]) | (EDGE & (rose | (m_pend & ~int_ack_i)));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic st);
      wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d; stall_i = st;
      @(negedge clk);
      wr_en_i = 1'b0; stall_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({count_o, compare_o, ip_o, timer_int_o, int_req_o, int_id_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: count=%h compare=%h ip=%h timer=%b req=%b id=%0d, all required 0",
                  count_o, compare_o, ip_o, timer_int_o, int_req_o, int_id_o);
      end
      checks++;
      if (count1 !== 32'd0) begin
         errors++; $display("FAIL reset_count1: got %h required 0", count1);
      end
   endtask

   task automatic test_prescale();
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (count_o !== 32'd5) begin
         errors++; $display("FAIL prescale_count: got %0d required 5", count_o);
      end
      checks++;
      if (count1 !== 32'd10) begin
         errors++; $display("FAIL prescale_count_div1: got %0d required 10", count1);
      end
      checks++;
      if (ip_o !== 8'h00 || int_req_o !== 1'b0) begin
         errors++; $display("FAIL prescale_idle: ip=%h req=%b required 00/0", ip_o, int_req_o);
      end
   endtask

   task automatic test_timer();
      int n = 0;
      status_i = 32'h0000_8001;
      wr(5'd11, 32'd8, 1'b0);
      checks++;
      if (compare_o !== 32'd8) begin
         errors++; $display("FAIL timer_compare_load: got %0d required 8", compare_o);
      end
      while (count_o !== 32'd8 && n < 40) begin
         @(negedge clk); n++;
      end
      checks++;
      if (n >= 40) begin
         errors++; $display("FAIL timer_wait: count=%0d never reached required 8", count_o);
      end
      checks++;
      if (timer_int_o !== 1'b0) begin
         errors++; $display("FAIL timer_early: got %b required 0 on equality edge", timer_int_o);
      end
      @(negedge clk);
      checks++;
      if (timer_int_o !== 1'b1 || ip_o[7] !== 1'b1) begin
         errors++; $display("FAIL timer_set: timer=%b ip7=%b required 1/1", timer_int_o, ip_o[7]);
      end
      checks++;
      if (int_req_o !== 1'b1 || int_id_o !== 3'd7) begin
         errors++; $display("FAIL timer_req: req=%b id=%0d required 1/7", int_req_o, int_id_o);
      end
      wr(5'd11, 32'd100, 1'b0);
      checks++;
      if (timer_int_o !== 1'b0 || compare_o !== 32'd100) begin
         errors++; $display("FAIL timer_clear: timer=%b compare=%0d required 0/100", timer_int_o, compare_o);
      end
   endtask

   task automatic test_timer_boundary();
      wr(5'd9, 32'hFFFF_FFFF, 1'b0);
      checks++;
      if (count1 !== 32'hFFFF_FFFF || count_o !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL count_load: count=%h count1=%h required ffffffff", count_o, count1);
      end
      @(negedge clk);
      checks++;
      if (count1 !== 32'd0) begin
         errors++; $display("FAIL count_wrap_div1: got %h required 0", count1);
      end
      @(negedge clk);
      checks++;
      if (count_o !== 32'd0) begin
         errors++; $display("FAIL count_wrap_div2: got %h required 0", count_o);
      end
      wr(5'd11, 32'd0, 1'b0);
      wr(5'd9, 32'd0, 1'b0);
      checks++;
      if (count_o !== 32'd0 || compare_o !== 32'd0) begin
         errors++; $display("FAIL zero_setup: count=%h compare=%h required 0/0", count_o, compare_o);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (timer_int_o !== 1'b0 || ip_o[7] !== 1'b0) begin
            errors++; $display("FAIL compare_zero: timer=%b ip7=%b required 0/0", timer_int_o, ip_o[7]);
         end
      end
      wr(5'd11, 32'd30, 1'b0);
      wr(5'd9, 32'd29, 1'b0);
      repeat (2) @(negedge clk);
      checks++;
      if (count_o !== 32'd30 || compare_o !== 32'd30) begin
         errors++; $display("FAIL equal_setup: count=%0d compare=%0d required 30/30", count_o, compare_o);
      end
      wr(5'd11, 32'd200, 1'b0);
      checks++;
      if (timer_int_o !== 1'b0 || compare_o !== 32'd200) begin
         errors++; $display("FAIL compare_write_vs_equal: timer=%b compare=%0d required 0/200", timer_int_o, compare_o);
      end
      @(negedge clk);
      checks++;
      if (timer_int_o !== 1'b0) begin
         errors++; $display("FAIL compare_write_after: timer=%b required 0", timer_int_o);
      end
   endtask

   task automatic test_edge_line();
      status_i = 32'h0;
      int_i[0] = 1'b1; @(negedge clk); int_i[0] = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (ip_o[2] !== 1'b0) begin
         errors++; $display("FAIL edge_early: ip2=%b required 0 after 3 edges", ip_o[2]);
      end
      @(negedge clk);
      checks++;
      if (ip_o[2] !== 1'b1) begin
         errors++; $display("FAIL edge_set: ip2=%b required 1 after 4 edges", ip_o[2]);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (ip_o[2] !== 1'b1) begin
         errors++; $display("FAIL edge_hold: ip2=%b required 1", ip_o[2]);
      end
      int_ack_i[0] = 1'b1; @(negedge clk); int_ack_i[0] = 1'b0;
      checks++;
      if (ip_o[2] !== 1'b0) begin
         errors++; $display("FAIL edge_ack: ip2=%b required 0", ip_o[2]);
      end
      int_i[0] = 1'b1; @(negedge clk); int_i[0] = 1'b0;
      repeat (2) @(negedge clk);
      int_ack_i[0] = 1'b1; @(negedge clk); int_ack_i[0] = 1'b0;
      checks++;
      if (ip_o[2] !== 1'b1) begin
         errors++; $display("FAIL edge_set_vs_ack: ip2=%b required 1", ip_o[2]);
      end
      int_ack_i[0] = 1'b1; @(negedge clk); int_ack_i[0] = 1'b0;
      checks++;
      if (ip_o[2] !== 1'b0) begin
         errors++; $display("FAIL edge_ack2: ip2=%b required 0", ip_o[2]);
      end
   endtask

   task automatic test_level_line();
      status_i = 32'h0000_2001;
      int_i[3] = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (ip_o[5] !== 1'b0) begin
         errors++; $display("FAIL level_early: ip5=%b required 0 after 2 edges", ip_o[5]);
      end
      @(negedge clk);
      checks++;
      if (ip_o[5] !== 1'b1 || int_req_o !== 1'b1 || int_id_o !== 3'd5) begin
         errors++; $display("FAIL level_set: ip5=%b req=%b id=%0d required 1/1/5", ip_o[5], int_req_o, int_id_o);
      end
      int_ack_i[3] = 1'b1; @(negedge clk); int_ack_i[3] = 1'b0;
      checks++;
      if (ip_o[5] !== 1'b1) begin
         errors++; $display("FAIL level_ack_ignored: ip5=%b required 1", ip_o[5]);
      end
      status_i = 32'h0000_0001; #1;
      checks++;
      if (int_req_o !== 1'b0) begin
         errors++; $display("FAIL level_im_masked: req=%b required 0", int_req_o);
      end
      status_i = 32'h0000_2003; #1;
      checks++;
      if (int_req_o !== 1'b0) begin
         errors++; $display("FAIL level_exl_masked: req=%b required 0", int_req_o);
      end
      int_i[3] = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (ip_o[5] !== 1'b1) begin
         errors++; $display("FAIL level_fall_early: ip5=%b required 1 after 2 edges", ip_o[5]);
      end
      @(negedge clk);
      checks++;
      if (ip_o[5] !== 1'b0) begin
         errors++; $display("FAIL level_clear: ip5=%b required 0 after 3 edges", ip_o[5]);
      end
   endtask

   task automatic test_sw_stall();
      wr(5'd13, 32'h0000_0300, 1'b0);
      checks++;
      if (ip_o[1:0] !== 2'b11) begin
         errors++; $display("FAIL sw_write: ip10=%b required 11", ip_o[1:0]);
      end
      wr(5'd13, 32'h0000_0000, 1'b1);
      checks++;
      if (ip_o[1:0] !== 2'b11) begin
         errors++; $display("FAIL sw_stalled: ip10=%b required 11", ip_o[1:0]);
      end
      status_i = 32'h0000_0301; #1;
      checks++;
      if (int_req_o !== 1'b1 || int_id_o !== 3'd1) begin
         errors++; $display("FAIL sw_req: req=%b id=%0d required 1/1", int_req_o, int_id_o);
      end
      wr(5'd13, 32'h0000_0000, 1'b0);
      checks++;
      if (ip_o[1:0] !== 2'b00) begin
         errors++; $display("FAIL sw_clear: ip10=%b required 00", ip_o[1:0]);
      end
   endtask

   task automatic test_mid_reset();
      status_i = 32'h0000_FF01;
      wr(5'd13, 32'h0000_0300, 1'b0);
      int_i = 6'b101000;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (ip_o !== 8'h00 || int_req_o !== 1'b0 || timer_int_o !== 1'b0 || count_o !== 32'd0) begin
         errors++; $display("FAIL mid_reset: ip=%h req=%b timer=%b count=%h required all 0",
                            ip_o, int_req_o, timer_int_o, count_o);
      end
      @(negedge clk);
      int_i = '0;
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic [7:0] eip;
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         eip = m_ip();
         checks++;
         if (count_o !== m_count(DIV) || count1 !== m_count(1)) begin
            errors++; $display("FAIL rnd_count: cyc %0d count=%h count1=%h required %h/%h",
                               n, count_o, count1, m_count(DIV), m_count(1));
         end
         checks++;
         if (compare_o !== m_compare || timer_int_o !== m_timer) begin
            errors++; $display("FAIL rnd_timer: cyc %0d compare=%h timer=%b required %h/%b",
                               n, compare_o, timer_int_o, m_compare, m_timer);
         end
         checks++;
         if (ip_o !== eip) begin
            errors++; $display("FAIL rnd_ip: cyc %0d ip=%h required %h", n, ip_o, eip);
         end
         checks++;
         if (int_req_o !== (status_i[0] & ~status_i[1] & ~status_i[2] & |(eip & status_i[15:8])) ||
             int_id_o !== m_id(eip & status_i[15:8])) begin
            errors++; $display("FAIL rnd_req: cyc %0d req=%b id=%0d required %b/%0d", n, int_req_o, int_id_o,
                               status_i[0] & ~status_i[1] & ~status_i[2] & |(eip & status_i[15:8]),
                               m_id(eip & status_i[15:8]));
         end
         int_i     = int_i ^ (6'($urandom) & 6'($urandom));
         int_ack_i = 6'($urandom) & 6'($urandom) & 6'($urandom);
         stall_i   = ($urandom_range(0, 3) == 0);
         wr_en_i   = ($urandom_range(0, 4) == 0);
         case ($urandom_range(0, 3))
            0: begin
               wr_addr_i = 5'd9;
               wr_data_i = ($urandom_range(0, 1) == 1) ? $urandom : m_compare - 32'($urandom_range(0, 4));
            end
            1: begin
               wr_addr_i = 5'd11;
               wr_data_i = m_count(DIV) + 32'($urandom_range(0, 6));
            end
            2: begin
               wr_addr_i = 5'd13;
               wr_data_i = $urandom;
            end
            default: begin
               wr_addr_i = 5'($urandom);
               wr_data_i = $urandom;
            end
         endcase
         status_i = $urandom;
         if ($urandom_range(0, 3) != 0) status_i[2:1] = 2'b00;
      end
      wr_en_i = 1'b0; stall_i = 1'b0; int_ack_i = '0;
   endtask

   initial begin
      rst_n = 1'b0; stall_i = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
      status_i = '0; int_i = '0; int_ack_i = '0;
      test_reset();
      test_prescale();
      test_timer();
      test_timer_boundary();
      test_edge_line();
      test_level_line();
      test_sw_stall();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cp0_int_ctrl.md
# cp0_int_ctrl

Parametrised CP0 interrupt and timer controller for the MIPS core. It owns the Count and Compare registers and the Cause.IP[7:0] pending field. It synchronises up to six external interrupt lines, each in level or edge mode, and adds a count prescaler. It sits beside the CP0 register file in the M stage and feeds ip_o, int_req_o and int_id_o to the exception-priority logic, which samples them in the same cycle.

## Interface
Parameters:
- NUM_HW_INT, 6: external lines used, 1..6. Line k maps to IP[k+2]. Unused IP bits read 0.
- SYNC_STAGES, 2: synchroniser flops per external line, 2..3.
- EDGE_MASK, 6'b000000: bit k=1 makes line k edge-triggered (sticky); bit k=0 makes it level.
- COUNT_DIV, 2: clocks per Count increment, power of two in 1..8.
- COMPARE_ZERO_EN, 0: when 0, Compare==0 never raises the timer interrupt.

Ports:
- clk, in, 1: single clock for all state.
- rst_n, in, 1: reset, asynchronous and active-low.
- stall_i, in, 1: while high, CSR writes are ignored.
- wr_en_i, in, 1: mtc0 write strobe.
- wr_addr_i, in, 5: CP0 register number. 9=Count, 11=Compare, 13=Cause; all others are ignored.
- wr_data_i, in, 32: write data.
- status_i, in, 32: current Status. Uses IE bit 0, EXL bit 1, ERL bit 2, IM bits 15:8.
- int_i, in, NUM_HW_INT: raw asynchronous external interrupt lines.
- int_ack_i, in, NUM_HW_INT: 1-cycle pulse that clears the sticky pending bit of an edge-mode line.
- count_o, out, 32: Count register.
- compare_o, out, 32: Compare register.
- ip_o, out, 8: Cause.IP7..IP0.
- timer_int_o, out, 1: sticky timer pending flag.
- int_req_o, out, 1: interrupt taken this cycle.
- int_id_o, out, 3: index of the highest-numbered pending and enabled IP bit.

## Operation
- A write is effective when wr_en_i & ~stall_i.
- Prescaler and Count:
  - The prescaler counts 0..COUNT_DIV-1. A tick occurs on the wrap.
  - On each tick, Count increments by 1, mod 2^32; 32'hFFFF_FFFF wraps to 0.
  - A Count write loads wr_data_i and clears the prescaler. If a write and a tick fall in the same cycle, the write wins.
- Timer interrupt:
  - Each cycle, timer_int_o sets if count_o==compare_o and (compare_o!=0 or COMPARE_ZERO_EN).
  - It stays set until a Compare write. The Compare write clears it and loads compare_o.
  - If a Compare write and an equality fall in the same cycle, the clear wins.
- External lines:
  - Each line passes through SYNC_STAGES flops, giving s[k].
  - Level mode: pend[k]=s[k], registered each cycle.
  - Edge mode: pend[k] sets on the rising edge of s[k] (s[k] & ~s_d[k]) and clears on int_ack_i[k]. If a set and an ack fall in the same cycle, the set wins. int_ack_i on a level-mode line has no effect.
- Cause / IP mapping:
  - ip[1:0] load from wr_data_i[9:8] on a Cause write. No other Cause bits are affected.
  - ip[k+2]=pend[k] for k<NUM_HW_INT.
  - ip[7]=pend[5] (when NUM_HW_INT==6) | timer_int_o.
- Request: int_req_o = IE & ~EXL & ~ERL & |(ip_o & IM). This is combinational from registered state.
- int_id_o = the highest set bit of (ip_o & IM); it is 0 when none is set. It is meaningful only while int_req_o=1.

## Timing
- Reset (asynchronous on rst_n low): the following clear to 0:
  - prescaler, count_o, compare_o;
  - all sync flops, pend, ip_o, timer_int_o;
  - int_req_o and int_id_o, as a consequence.
- Reset release: the first tick occurs COUNT_DIV cycles after the first clk edge with rst_n high.
- Register write latency: Count, Compare and Cause writes become visible on the outputs 1 cycle after the write edge.
- External line latency, int_i rise to ip_o[k+2]:
  - level mode: SYNC_STAGES+1 edges;
  - edge mode: SYNC_STAGES+2 edges, because of the s_d compare.
- Timer latency: count_o becomes equal to compare_o at edge t; timer_int_o=1 after edge t+1.
- Reset mid-operation drops every pending interrupt, with no glitch on int_req_o beyond the asynchronous clear.
- A stalled write is lost, not queued. The pipeline reissues it.

## Test plan
- Reset and prescale: with COUNT_DIV=2, release reset and run 10 cycles -> count_o=5, ip_o=0, int_req_o=0.
- Timer set and clear: write Compare=8 and run until count_o=8 -> timer_int_o=1 one cycle later, ip_o[7]=1. With status_i=32'h0000_8001, int_req_o=1 and int_id_o=7. Then write Compare=100 -> timer_int_o=0 the next cycle.
- Timer boundary cases:
  - write Count=32'hFFFF_FFFF with COUNT_DIV=1 -> next cycle count_o=0;
  - with COMPARE_ZERO_EN=0, no timer interrupt while compare_o=0;
  - a Compare write in the same cycle as equality -> timer_int_o stays 0 that edge.
- Edge-mode line: with EDGE_MASK=6'b000001 and SYNC_STAGES=2, pulse int_i[0] for 1 cycle -> ip_o[2]=1 after 4 edges and held. An int_ack_i[0] pulse clears it. An ack in the same cycle as a new edge keeps ip_o[2]=1.
- Level-mode line and masking:
  - hold int_i[3]=1 -> ip_o[5]=1 after 3 edges; deassert -> it clears after 3 edges;
  - IM[5]=0 or EXL=1 -> int_req_o=0 while ip_o[5]=1.
- Software interrupts and stall:
  - write Cause=32'h0000_0300 -> ip_o[1:0]=2'b11;
  - the same write with stall_i=1 -> ip_o unchanged;
  - with IM=8'h03 and IE=1 -> int_id_o=1.
